// File: rtl/eth_switch_port_source.sv
// Frame source for one Rx-side switch port: streams a buffered frame with first/last
// status, zero-pads short frames to MIN_LEN and enforces an inter-packet gap.
module eth_switch_port_source #(
    parameter int ADDR_WIDTH = 11,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514,
    parameter int IPG        = 12
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  send_req,
    input  logic [ADDR_WIDTH-1:0] send_len,
    input  logic                  hold,
    output logic                  send_busy,
    output logic                  send_done,
    output logic                  send_err,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    input  logic [7:0]            buf_data,
    output logic                  RxValid,
    output logic [7:0]            RxD,
    output logic [1:0]            RxSt
);

    localparam int GW = (IPG > 1) ? $clog2(IPG) : 1;
    localparam logic [ADDR_WIDTH-1:0] MinLen  = ADDR_WIDTH'(MIN_LEN);
    localparam logic [ADDR_WIDTH-1:0] MaxLen  = ADDR_WIDTH'(MAX_LEN);
    localparam logic [GW-1:0]         LastGap = GW'(IPG - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] total_q, total_d;
    logic [ADDR_WIDTH-1:0] byteCnt_q, byteCnt_d;
    logic [GW-1:0]         gapCnt_q, gapCnt_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  busy_d, done_d, err_d, valid_d;
    logic [7:0]            rxd_d;
    logic [1:0]            rxSt_d;
    logic                  lastByte;

    assign lastByte = (byteCnt_q == total_q - ADDR_WIDTH'(1));

    // buf_addr rests at 0 outside a frame, so the RAM already presents byte 0 during
    // FETCH and the accept edge can move the address straight on to 1.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        total_d   = total_q;
        byteCnt_d = byteCnt_q;
        gapCnt_d  = gapCnt_q;
        addr_d    = buf_addr;
        busy_d    = send_busy;
        done_d    = 1'b0;
        err_d     = 1'b0;
        valid_d   = 1'b0;
        rxd_d     = 8'h00;
        rxSt_d    = 2'b00;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                busy_d = 1'b0;
                if (send_req && !hold) begin
                    if (send_len != '0 && send_len <= MaxLen) begin
                        len_d     = send_len;
                        total_d   = (send_len < MinLen) ? MinLen : send_len;
                        addr_d    = ADDR_WIDTH'(1);
                        byteCnt_d = '0;
                        busy_d    = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH, SEND: begin
                valid_d   = 1'b1;
                rxd_d     = (byteCnt_q < len_q) ? buf_data : 8'h00;
                rxSt_d    = {lastByte, byteCnt_q == '0};
                byteCnt_d = byteCnt_q + ADDR_WIDTH'(1);
                state_d   = SEND;
                if (buf_addr < len_q) begin
                    addr_d = buf_addr + ADDR_WIDTH'(1);
                end
                if (lastByte) begin
                    done_d   = 1'b1;
                    addr_d   = '0;
                    gapCnt_d = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                // The last-byte cycle counts as the first gap cycle.
                if (gapCnt_q == LastGap) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            total_q   <= '0;
            byteCnt_q <= '0;
            gapCnt_q  <= '0;
            buf_addr  <= '0;
            send_busy <= 1'b0;
            send_done <= 1'b0;
            send_err  <= 1'b0;
            RxValid   <= 1'b0;
            RxD       <= 8'h00;
            RxSt      <= 2'b00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            total_q   <= total_d;
            byteCnt_q <= byteCnt_d;
            gapCnt_q  <= gapCnt_d;
            buf_addr  <= addr_d;
            send_busy <= busy_d;
            send_done <= done_d;
            send_err  <= err_d;
            RxValid   <= valid_d;
            RxD       <= rxd_d;
            RxSt      <= rxSt_d;
        end
    end

endmodule

// File: tb/tb_eth_switch_port_source.sv
// Directed bench for eth_switch_port_source: table of frame lengths plus hand-written
// sequences for back-to-back frames, hold and mid-frame reset.
module tb_eth_switch_port_source;

    localparam int AW      = 11;
    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;
    localparam int IPG     = 12;

    typedef struct {
        int len;
        int total;
        bit expErr;
    } vec_t;

    logic          sysclk = 1'b0;
    logic          reset = 1'b0;
    logic          send_req = 1'b0;
    logic [AW-1:0] send_len = '0;
    logic          hold = 1'b0;
    logic          send_busy, send_done, send_err;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          RxValid;
    logic [7:0]    RxD;
    logic [1:0]    RxSt;

    logic [7:0] mem [0:2047];
    int testsRun = 0;
    int testsFailed = 0;
    vec_t vecs [8];

    eth_switch_port_source #(
        .ADDR_WIDTH(AW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IPG(IPG)
    ) dut (
        .sysclk(sysclk), .reset(reset), .send_req(send_req), .send_len(send_len),
        .hold(hold), .send_busy(send_busy), .send_done(send_done), .send_err(send_err),
        .buf_addr(buf_addr), .buf_data(buf_data), .RxValid(RxValid), .RxD(RxD), .RxSt(RxSt)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) buf_data <= mem[buf_addr];

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input int len, input logic h);
        send_req = req;
        send_len = AW'(len);
        hold     = h;
    endtask

    function automatic logic [7:0] expByte(input int k, input int len);
        return (k < len) ? mem[k] : 8'h00;
    endfunction

    // Checks bytes 'from'..total-1; the caller has just sampled byte from-1.
    task automatic checkBytes(input string tag, input int len, input int total, input int from, input int holdAt);
        int errs = 0;
        int maxAddr = 0;
        for (int k = from; k < total; k++) begin
            @(negedge sysclk);
            if (k == holdAt) hold = 1'b1;
            if (RxValid !== 1'b1 || RxD !== expByte(k, len) ||
                RxSt !== {k == total - 1, k == 0} || send_done !== (k == total - 1))
                errs++;
            if (int'(buf_addr) > maxAddr) maxAddr = int'(buf_addr);
        end
        checkOutput({tag, " byte stream"}, errs, 0);
        checkOutput({tag, " buf_addr bounded by len"}, maxAddr <= len, 1);
    endtask

    // After the last byte, busy must stay high for IPG-1 more cycles with the bus idle.
    task automatic checkGap(input string tag);
        int busyCycles = 0;
        int busErrs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (RxValid !== 1'b0 || RxD !== 8'h00 || RxSt !== 2'b00) busErrs++;
            if (send_busy !== 1'b1) break;
            busyCycles++;
        end
        checkOutput({tag, " gap busy cycles"}, busyCycles, IPG - 1);
        checkOutput({tag, " gap bus idle"}, busErrs, 0);
    endtask

    task automatic runFrame(input string tag, input int len, input int total);
        applyStimulus(1'b1, len, 1'b0);
        @(posedge sysclk);
        @(negedge sysclk);
        applyStimulus(1'b0, len, 1'b0);
        checkOutput({tag, " fetch RxValid"}, RxValid, 0);
        checkOutput({tag, " fetch busy"}, send_busy, 1);
        checkBytes(tag, len, total, 0, -1);
        checkGap(tag);
    endtask

    task automatic runReject(input string tag, input int len);
        applyStimulus(1'b1, len, 1'b0);
        @(negedge sysclk);
        checkOutput({tag, " err pulse"}, send_err, 1);
        checkOutput({tag, " err busy"}, send_busy, 0);
        checkOutput({tag, " err RxValid"}, RxValid, 0);
        applyStimulus(1'b0, 0, 1'b0);
        @(negedge sysclk);
        checkOutput({tag, " err cleared"}, send_err, 0);
        checkOutput({tag, " err RxValid after"}, RxValid, 0);
    endtask

    initial begin
        int lowCycles;
        int bytes;
        int seen;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);

        vecs[0] = '{len: 64,   total: 64,   expErr: 1'b0};
        vecs[1] = '{len: 20,   total: 60,   expErr: 1'b0};
        vecs[2] = '{len: 60,   total: 60,   expErr: 1'b0};
        vecs[3] = '{len: 1,    total: 60,   expErr: 1'b0};
        vecs[4] = '{len: 61,   total: 61,   expErr: 1'b0};
        vecs[5] = '{len: 0,    total: 0,    expErr: 1'b1};
        vecs[6] = '{len: 1515, total: 0,    expErr: 1'b1};
        vecs[7] = '{len: 1514, total: 1514, expErr: 1'b0};

        repeat (2) @(negedge sysclk);
        checkOutput("reset RxValid", RxValid, 0);
        checkOutput("reset busy", send_busy, 0);
        checkOutput("reset buf_addr", buf_addr, 0);
        checkOutput("reset err/done", {send_err, send_done}, 0);
        reset = 1'b1;
        @(negedge sysclk);

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("len=%0d", vecs[v].len);
            if (vecs[v].expErr) runReject(tag, vecs[v].len);
            else runFrame(tag, vecs[v].len, vecs[v].total);
            @(negedge sysclk);
        end

        // Back-to-back frames with send_req held
        applyStimulus(1'b1, 60, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sysclk);
            if (RxValid === 1'b1) seen = 1;
        end
        checkOutput("b2b first frame start", seen, 1);
        bytes = 1;
        for (int i = 0; i < 100 && RxSt[1] !== 1'b1; i++) begin
            @(negedge sysclk);
            if (RxValid === 1'b1) bytes++;
        end
        checkOutput("b2b first frame length", bytes, 60);
        lowCycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sysclk);
            if (RxValid === 1'b1) break;
            lowCycles++;
        end
        checkOutput("b2b RxValid-low cycles", lowCycles, IPG + 1);
        checkOutput("b2b second frame first flag", RxSt, 2'b01);
        applyStimulus(1'b0, 60, 1'b0);
        checkBytes("b2b second frame", 60, 60, 1, -1);
        checkGap("b2b");
        seen = 0;
        repeat (20) begin
            @(negedge sysclk);
            if (RxValid === 1'b1) seen = 1;
        end
        checkOutput("b2b no third frame", seen, 0);

        // hold blocks start, but is ignored once the frame is accepted
        applyStimulus(1'b1, 60, 1'b1);
        seen = 0;
        repeat (6) begin
            @(negedge sysclk);
            if (RxValid !== 1'b0 || send_busy !== 1'b0) seen = 1;
        end
        checkOutput("hold blocks start", seen, 0);
        applyStimulus(1'b1, 60, 1'b0);
        @(negedge sysclk);
        applyStimulus(1'b0, 60, 1'b0);
        checkOutput("hold release fetch RxValid", RxValid, 0);
        @(negedge sysclk);
        checkOutput("hold release first byte", {RxValid, RxSt, RxD}, {1'b1, 2'b01, mem[0]});
        checkBytes("hold mid-frame", 60, 60, 1, 5);
        hold = 1'b0;
        checkGap("hold");

        // Asynchronous reset in the middle of a frame
        applyStimulus(1'b1, 60, 1'b0);
        @(posedge sysclk);
        @(negedge sysclk);
        applyStimulus(1'b0, 60, 1'b0);
        repeat (11) @(negedge sysclk);
        checkOutput("pre-reset byte 10", {RxValid, RxD}, {1'b1, mem[10]});
        reset = 1'b0;
        #1;
        checkOutput("mid-frame reset outputs", {RxValid, RxD, RxSt, send_busy}, 0);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        runFrame("after reset", 60, 60);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
